// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int unsigned CORE_XLEN   = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_ALIGN = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// Next fetch-PC selection: redirect target, else sequential advance on
// capture, else hold.
// Ports:
//   fetch_pc        current fetch address
//   redirect        redirect accepted this cycle
//   redirect_target redirect address (already aligned or checked upstream)
//   capture         a word is being captured this cycle
//   next_pc_c       combinational next value of fetch_pc
module instr_fetch_pc_gen
    import instr_fetch_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN
) (
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            capture,
    output logic [XLEN-1:0] next_pc_c
);

    // Sequential add wraps naturally modulo 2^XLEN.
    always_comb begin
        next_pc_c = fetch_pc;
        if (redirect) begin
            next_pc_c = redirect_target;
        end else if (capture) begin
            next_pc_c = fetch_pc + XLEN'(INSTR_ALIGN);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the fetch PC, requests words from
// instruction memory over a req/ready handshake and presents them to
// decode through a single-entry output register.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned
// redirect targets into a sticky FAULT state (left only by reset);
// otherwise low target bits are masked and fetch_fault is tied low.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req/addr/ready/rdata  instruction memory handshake
//   redirect, redirect_pc      taken branch/jump from execute
//   stall                      decode cannot accept
//   instr, pc, instr_valid     output register to decode
//   fetch_fault                misaligned redirect trap
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               stall,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    pc,
    output logic               instr_valid,
    output logic               fetch_fault
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] next_pc_c;
    logic [XLEN-1:0] redirect_target_c;
    logic            redirect_take_c;
    logic            misalign_c;
    logic            capture_c;
    logic            transfer_c;
    logic            imem_req_c;

    // FAULT ignores redirects; in BOOT/RUN a redirect always wins.
    assign redirect_take_c = redirect && (state != FAULT);
    assign transfer_c      = instr_valid && !stall;
    assign capture_c       = imem_req_c && imem_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target_c = redirect_pc;
    assign misalign_c        = redirect_take_c && (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_target_c = redirect_pc & ~XLEN'(INSTR_ALIGN - 1);
    assign misalign_c        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = misalign_c ? FAULT : RUN;
            RUN:     state_next = misalign_c ? FAULT : RUN;
            FAULT:   state_next = FAULT;
            default: state_next = BOOT;
        endcase
    end

    // Output logic: request only when the output register can take the word.
    always_comb begin
        imem_req_c = 1'b0;
        if (state == RUN && !redirect && (!instr_valid || !stall)) begin
            imem_req_c = 1'b1;
        end
    end

    assign imem_req  = imem_req_c;
    assign imem_addr = fetch_pc;

    instr_fetch_pc_gen #(
        .XLEN (XLEN)
    ) u_pc_gen (
        .fetch_pc        (fetch_pc),
        .redirect        (redirect_take_c),
        .redirect_target (redirect_target_c),
        .capture         (capture_c),
        .next_pc_c       (next_pc_c)
    );

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else begin
            fetch_pc <= next_pc_c;
        end
    end

    // Output register to decode; a redirect squashes any returning word.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr       <= NOP_INSTR;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
        end else if (redirect_take_c) begin
            instr_valid <= 1'b0;
            if (misalign_c) begin
                pc <= redirect_pc;
            end
        end else if (capture_c) begin
            instr       <= imem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
        end else if (transfer_c) begin
            instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_fault <= 1'b0;
        end else if (misalign_c) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        fetch_fault;

    int checks;
    int failures;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word derived from its address so each word is distinct.
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] p,
                             input logic [31:0] i);
        check({tag, ".valid"}, 32'(instr_valid), 32'(v));
        check({tag, ".pc"}, pc, p);
        check({tag, ".instr"}, instr, i);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        imem_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;

        // Reset held two cycles, ready ignored.
        tick();
        tick();
        check("rst.req", 32'(imem_req), 32'd0);
        check("rst.addr", imem_addr, 32'h0);
        check("rst.fault", 32'(fetch_fault), 32'd0);
        check_out("rst", 1'b0, 32'h0, 32'h0000_0013);

        // BOOT cycle: no request yet.
        reset = 1'b0;
        #1;
        check("boot.req", 32'(imem_req), 32'd0);
        tick();
        check("run.req", 32'(imem_req), 32'd1);
        check("run.addr", imem_addr, 32'h0);
        check_out("run", 1'b0, 32'h0, 32'h0000_0013);

        // Streaming at one word per cycle.
        tick();
        check_out("s0", 1'b1, 32'h0, 32'hA5A5_0000);
        tick();
        check_out("s4", 1'b1, 32'h4, 32'hA5A5_0004);
        tick();
        check_out("s8", 1'b1, 32'h8, 32'hA5A5_0008);
        check("s8.addr", imem_addr, 32'hC);

        // Stall with a valid word: output frozen, no request.
        stall = 1'b1;
        #1;
        check("stall.req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("stall", 1'b1, 32'h8, 32'hA5A5_0008);
            check("stall.addr", imem_addr, 32'hC);
        end
        stall = 1'b0;
        #1;
        check("unstall.req", 32'(imem_req), 32'd1);
        tick();
        check_out("s12", 1'b1, 32'hC, 32'hA5A5_000C);
        check("s12.addr", imem_addr, 32'h10);

        // Two wait states at address 16.
        imem_ready = 1'b0;
        tick();
        check_out("w1", 1'b0, 32'hC, 32'hA5A5_000C);
        check("w1.addr", imem_addr, 32'h10);
        check("w1.req", 32'(imem_req), 32'd1);
        tick();
        check_out("w2", 1'b0, 32'hC, 32'hA5A5_000C);
        check("w2.addr", imem_addr, 32'h10);
        imem_ready = 1'b1;
        tick();
        check_out("s16", 1'b1, 32'h10, 32'hA5A5_0010);
        check("s16.addr", imem_addr, 32'h14);

        // Redirect coinciding with ready at address 20: word discarded.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check("rd.req", 32'(imem_req), 32'd0);
        tick();
        check_out("rd", 1'b0, 32'h10, 32'hA5A5_0010);
        check("rd.addr", imem_addr, 32'h100);
        redirect = 1'b0;
        #1;
        check("rd1.req", 32'(imem_req), 32'd1);
        tick();
        check_out("s100", 1'b1, 32'h100, 32'hA5A5_0100);
        check("s100.addr", imem_addr, 32'h104);

        // Address wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        check("wrapr.addr", imem_addr, 32'hFFFF_FFFC);
        check("wrapr.valid", 32'(instr_valid), 32'd0);
        redirect = 1'b0;
        tick();
        check_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
        check("wrap.addr", imem_addr, 32'h0);

        // Misaligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis.fault", 32'(fetch_fault), 32'd1);
        check("mis.pc", pc, 32'h102);
        check("mis.valid", 32'(instr_valid), 32'd0);
        #1;
        check("mis.req", 32'(imem_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        stall       = 1'b1;
        tick();
        tick();
        check("flt.fault", 32'(fetch_fault), 32'd1);
        check("flt.req", 32'(imem_req), 32'd0);
        check("flt.pc", pc, 32'h102);
        redirect = 1'b0;
        stall    = 1'b0;
`else
        check("mis.fault", 32'(fetch_fault), 32'd0);
        check("mis.addr", imem_addr, 32'h100);
        check_out("mis", 1'b0, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
        tick();
        check_out("mis1", 1'b1, 32'h100, 32'hA5A5_0100);
        check("mis1.fault", 32'(fetch_fault), 32'd0);
`endif

        // Reset mid-transaction abandons everything.
        reset = 1'b1;
        tick();
        check("rst2.fault", 32'(fetch_fault), 32'd0);
        check("rst2.addr", imem_addr, 32'h0);
        check("rst2.req", 32'(imem_req), 32'd0);
        check_out("rst2", 1'b0, 32'h0, 32'h0000_0013);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
